fp_round_pack: RTL and testbench
================================

# fp_round_pack

Rounding and packing stage of the FP datapath. Sits directly downstream of the normalizer and consumes its normalized mantissa, adjusted exponent and flags. Applies IEEE-754 round-to-nearest-even, handles rounding carry, overflow-to-infinity and subnormal/zero encoding, and packs a half or single result word. Two-stage pipeline with valid/ready handshake on both sides.

## Interface
- No parameters.
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  asynchronous, active-high reset
- IN_VALID  input  1  input beat valid
- IN_READY  output  1  stage can accept a beat this cycle
- MODE_FP  input  1  0 = half, 1 = single
- SIGN  input  1  result sign
- SPECIAL  input  2  00 finite, 01 infinity, 10 NaN, 11 treated as NaN
- MANT  input  49  normalized mantissa; hidden bit at [47], fraction/guard bits [46:0]
- EXP  input  9  biased exponent from normalizer
- FLAGS  input  5  {overflow, underflow, divzero, invalid, inexact}
- OUT_VALID  output  1  result valid
- OUT_READY  input  1  consumer accepts result
- RESULT  output  32  packed result; half mode uses [15:0], [31:16] = 0
- FLAGS_OUT  output  5  same bit order as FLAGS

## Operation
- Field split, single: frac = MANT[46:24], G = MANT[23], R = MANT[22], S = |MANT[21:0]. Half: frac = MANT[46:37], G = MANT[36], R = MANT[35], S = |MANT[34:0].
- tiny = (MANT[47] == 0). Effective exponent field = tiny ? 0 : EXP (8 bits single, 5 bits half).
- inc = G & (R | S | frac[0]). inexact = G | R | S.
- Stage 1 registers sign, mode, special, {exp_eff, frac}, inc, inexact, tiny and EXP > MAX_EXP (MAX_EXP = 254 single, 30 half).
- Stage 2: sum = {exp_eff, frac} + inc, width = exp field + frac field + 1. Carry from frac into exp is the correct renormalization, including subnormal-to-normal at exp field 1.
- Overflow when EXP > MAX_EXP or sum exp field = all ones: RESULT = signed infinity, FLAGS_OUT[4] = 1, FLAGS_OUT[0] = 1.
- Underflow: FLAGS_OUT[3] = FLAGS[3] | (tiny & inexact).
- Zero: MANT == 0 and SPECIAL = 00 gives signed zero. FLAGS_OUT = {0, 0, FLAGS[2:1], 0}.
- SPECIAL 01 gives signed infinity; SPECIAL 1x gives canonical qNaN (0x7FC00000 / 0x7E00). Rounding logic is bypassed, FLAGS_OUT = {0, 0, FLAGS[2:1], 0}.
- Otherwise FLAGS_OUT = {ovf, unf, FLAGS[2:1], inexact | FLAGS[0]}.

## Timing
- Latency: 2 cycles from an accepted input (IN_VALID & IN_READY) to OUT_VALID. Throughput: 1 beat per cycle.
- Stage 2 loads when !v2 | OUT_READY. Stage 1 loads when !v1 | stage-2-load.
- IN_READY = !v1 | !v2 | OUT_READY. This is combinational from OUT_READY.
- While OUT_VALID & !OUT_READY, RESULT and FLAGS_OUT hold stable and no beat is dropped or duplicated.
- Simultaneous accept and emit in the same cycle: both happen, and the occupancy is unchanged.
- Reset, including mid-operation: v1 = v2 = 0, OUT_VALID = 0, RESULT = 0, FLAGS_OUT = 0, IN_READY = 1 after reset is released. In-flight beats are discarded.
- Data registers update only when their stage loads. Bubbles do not change RESULT.

## Configuration
- FP_ROUND_FTZ_EN defined: any tiny finite nonzero result flushes to signed zero with FLAGS_OUT[3] = 1 and FLAGS_OUT[0] = 1. No subnormal encoding is ever produced.
- Not defined: gradual underflow as described in Operation.

## Test plan
- Single, MANT = 2^47, EXP = 127 -> RESULT 0x3F800000, FLAGS_OUT 0, OUT_VALID exactly 2 cycles after accept.
- Single tie: MANT = 2^47 + 2^23 -> 0x3F800000 (round to even). MANT = 2^47 + 2^24 + 2^23 -> 0x3F800002. Both with FLAGS_OUT = 5'b00001.
- Single carry and overflow: MANT[47:23] all ones, EXP = 127 -> 0x40000000, inexact. Same MANT with EXP = 254 -> 0x7F800000, FLAGS_OUT 5'b10001.
- Half: MODE_FP = 0, MANT = 2^47, EXP = 15 -> 0x00003C00. SPECIAL = 10 -> 0x00007E00.
- Subnormal: single, EXP = 1, MANT = 2^46 + 2^22 -> 0x00400000 with FLAGS_OUT 5'b01001. With FP_ROUND_FTZ_EN -> 0x00000000, same flags.
- Backpressure: OUT_READY = 0, drive 3 back-to-back beats. 2 are accepted and IN_READY drops. Release OUT_READY: all 3 results emerge in order, RESULT stable while stalled. Assert RST mid-stream: OUT_VALID = 0 immediately.

Source files
------------

// File: rtl/fp_round_pack.sv
// Purpose : IEEE-754 round-to-nearest-even and pack of a normalized mantissa into a half or single word.
// Latency : 2 cycles from accepted input beat to OUT_VALID, 1 beat per cycle throughput.
// Backpr. : IN_READY = !v1 | !v2 | OUT_READY (combinational from OUT_READY); a stalled result holds stable.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   IN_VALID/IN_READY input handshake
//   MODE_FP           0 = half, 1 = single
//   SIGN, SPECIAL     result sign; 00 finite, 01 inf, 1x NaN
//   MANT[48:0]        normalized mantissa, hidden bit at [47]
//   EXP[8:0]          biased exponent from the normalizer
//   FLAGS[4:0]        {overflow, underflow, divzero, invalid, inexact}
//   OUT_VALID/OUT_READY output handshake
//   RESULT[31:0]      packed word; half mode in [15:0] with [31:16] = 0
//   FLAGS_OUT[4:0]    same bit order as FLAGS
//
// Build option: define FP_ROUND_FTZ_EN to flush tiny finite nonzero results
// to signed zero instead of producing subnormal encodings.

module fp_round_pack (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        MODE_FP,
    input  logic        SIGN,
    input  logic [1:0]  SPECIAL,
    input  logic [48:0] MANT,
    input  logic [8:0]  EXP,
    input  logic [4:0]  FLAGS,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] RESULT,
    output logic [4:0]  FLAGS_OUT
);

    // ------------------------------------------------------------------
    // Handshake / occupancy
    // ------------------------------------------------------------------
    logic v1;
    logic v2;
    logic ld1;
    logic ld2;

    assign ld2       = ~v2 | OUT_READY;
    assign ld1       = ~v1 | ld2;
    assign IN_READY  = ld1;
    assign OUT_VALID = v2;

    // The incoming overflow flag is superseded by the overflow this stage
    // computes itself, so it is intentionally not consumed.
    logic unused_flag_ovf;
    assign unused_flag_ovf = FLAGS[4];

    // ------------------------------------------------------------------
    // Stage 1 combinational: field split and round decision
    // ------------------------------------------------------------------
    logic [22:0] frac_in;
    logic [7:0]  exp_field_in;
    logic [30:0] field_in;
    logic        g_in;
    logic        r_in;
    logic        s_in;
    logic        tiny_in;
    logic        inc_in;
    logic        inexact_in;
    logic        over_exp_in;
    logic        zero_in;

    always_comb begin
        frac_in      = '0;
        exp_field_in = '0;
        g_in         = 1'b0;
        r_in         = 1'b0;
        s_in         = 1'b0;
        over_exp_in  = 1'b0;
        tiny_in      = ~MANT[47];

        if (MODE_FP) begin
            frac_in      = MANT[46:24];
            g_in         = MANT[23];
            r_in         = MANT[22];
            s_in         = |MANT[21:0];
            exp_field_in = EXP[7:0];
            over_exp_in  = (EXP > 9'd254);
        end else begin
            frac_in      = {13'b0, MANT[46:37]};
            g_in         = MANT[36];
            r_in         = MANT[35];
            s_in         = |MANT[34:0];
            exp_field_in = {3'b0, EXP[4:0]};
            over_exp_in  = (EXP > 9'd30);
        end

        // Without the hidden bit the value is subnormal: exponent field 0.
        if (tiny_in) begin
            exp_field_in = '0;
        end

        // Exponent and fraction are kept concatenated so a single adder
        // in stage 2 handles the rounding carry into the exponent.
        if (MODE_FP) begin
            field_in = {exp_field_in, frac_in};
        end else begin
            field_in = {16'b0, exp_field_in[4:0], frac_in[9:0]};
        end

        inc_in     = g_in & (r_in | s_in | frac_in[0]);
        inexact_in = g_in | r_in | s_in;
        zero_in    = (MANT == '0);
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic        s1_sign;
    logic        s1_mode;
    logic [1:0]  s1_special;
    logic [30:0] s1_field;
    logic        s1_inc;
    logic        s1_inexact;
    logic        s1_tiny;
    logic        s1_over_exp;
    logic        s1_zero;
    logic [3:0]  s1_flags;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (ld1) begin
                v1 <= IN_VALID;
            end
            if (ld2) begin
                v2 <= v1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_sign     <= 1'b0;
            s1_mode     <= 1'b0;
            s1_special  <= 2'b00;
            s1_field    <= '0;
            s1_inc      <= 1'b0;
            s1_inexact  <= 1'b0;
            s1_tiny     <= 1'b0;
            s1_over_exp <= 1'b0;
            s1_zero     <= 1'b0;
            s1_flags    <= '0;
        end else if (ld1 && IN_VALID) begin
            s1_sign     <= SIGN;
            s1_mode     <= MODE_FP;
            s1_special  <= SPECIAL;
            s1_field    <= field_in;
            s1_inc      <= inc_in;
            s1_inexact  <= inexact_in;
            s1_tiny     <= tiny_in;
            s1_over_exp <= over_exp_in;
            s1_zero     <= zero_in;
            s1_flags    <= FLAGS[3:0];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: increment, overflow and encoding select
    // ------------------------------------------------------------------
    logic [30:0] sum;
    logic        exp_ones;
    logic        ovf;
    logic        unf;
    logic [31:0] sign_word;
    logic [31:0] inf_word;
    logic [31:0] nan_word;
    logic [31:0] res_nxt;
    logic [4:0]  flags_nxt;

    always_comb begin
        // A carry out of the fraction bumps the exponent, which is exactly
        // the renormalization needed (including subnormal -> exp field 1).
        // A carry past the exponent field requires an all-ones exponent,
        // which is already flagged as out of range.
        sum       = s1_field + {30'b0, s1_inc};
        exp_ones  = s1_mode ? (sum[30:23] == 8'hFF) : (sum[14:10] == 5'h1F);
        ovf       = s1_over_exp | exp_ones;
        unf       = s1_flags[3] | (s1_tiny & s1_inexact);
        sign_word = s1_mode ? {s1_sign, 31'b0} : {16'b0, s1_sign, 15'b0};
        inf_word  = s1_mode ? 32'h7F80_0000 : 32'h0000_7C00;
        nan_word  = s1_mode ? 32'h7FC0_0000 : 32'h0000_7E00;

        res_nxt   = sign_word | (s1_mode ? {1'b0, sum} : {17'b0, sum[14:0]});
        flags_nxt = {1'b0, unf, s1_flags[2:1], s1_inexact | s1_flags[0]};

        if (s1_special[1]) begin
            res_nxt   = nan_word;
            flags_nxt = {2'b00, s1_flags[2:1], 1'b0};
        end else if (s1_special[0]) begin
            res_nxt   = sign_word | inf_word;
            flags_nxt = {2'b00, s1_flags[2:1], 1'b0};
        end else if (s1_zero) begin
            res_nxt   = sign_word;
            flags_nxt = {2'b00, s1_flags[2:1], 1'b0};
        end else if (ovf) begin
            res_nxt   = sign_word | inf_word;
            flags_nxt = {1'b1, unf, s1_flags[2:1], 1'b1};
        end
`ifdef FP_ROUND_FTZ_EN
        else if (s1_tiny) begin
            res_nxt   = sign_word;
            flags_nxt = {1'b0, 1'b1, s1_flags[2:1], 1'b1};
        end
`endif
    end

    // ------------------------------------------------------------------
    // Stage 2 registers: only loaded by a real beat so bubbles and stalls
    // leave RESULT / FLAGS_OUT untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RESULT    <= '0;
            FLAGS_OUT <= '0;
        end else if (ld2 && v1) begin
            RESULT    <= res_nxt;
            FLAGS_OUT <= flags_nxt;
        end
    end

endmodule

// File: tb/tb_fp_round_pack.sv
// Purpose : self-checking bench for fp_round_pack (directed plan vectors,
//           backpressure, randomized traffic against a reference model, reset).
// Timing  : inputs driven 1 time unit after the rising edge, outputs sampled
//           1 time unit later, never on the edge itself.

module tb_fp_round_pack;

    logic        CLK;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic        MODE_FP;
    logic        SIGN;
    logic [1:0]  SPECIAL;
    logic [48:0] MANT;
    logic [8:0]  EXP;
    logic [4:0]  FLAGS;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] RESULT;
    logic [4:0]  FLAGS_OUT;

    int n_vec;
    int n_bad;

    typedef struct {
        logic        mode;
        logic        sign;
        logic [1:0]  special;
        logic [48:0] mant;
        logic [8:0]  exp;
        logic [4:0]  flags;
    } beat_t;

    fp_round_pack dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .MODE_FP   (MODE_FP),
        .SIGN      (SIGN),
        .SPECIAL   (SPECIAL),
        .MANT      (MANT),
        .EXP       (EXP),
        .FLAGS     (FLAGS),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .RESULT    (RESULT),
        .FLAGS_OUT (FLAGS_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    // Reference model: rounds by comparing the discarded remainder with
    // half an ulp, then assembles the word arithmetically.
    function automatic logic [36:0] ref_model(input beat_t b);
        logic [63:0] m, kept, rem, halfp, expe, val, emask;
        logic [31:0] r, sbit, inf_w;
        logic [4:0]  f;
        logic [8:0]  maxe;
        logic        tiny, inexact, up, ovf, unf;
        int          fw, sh;
        fw      = b.mode ? 23 : 10;
        sh      = 47 - fw;
        maxe    = b.mode ? 9'd254 : 9'd30;
        emask   = b.mode ? 64'hFF : 64'h1F;
        m       = {17'b0, b.mant[46:0]};
        kept    = m >> sh;
        rem     = m - (kept << sh);
        halfp   = 64'd1 << (sh - 1);
        inexact = (rem != 64'd0);
        up      = (rem > halfp) || ((rem == halfp) && kept[0]);
        tiny    = !b.mant[47];
        expe    = tiny ? 64'd0 : ({55'b0, b.exp} & emask);
        val     = (expe << fw) + kept + {63'b0, up};
        ovf     = (b.exp > maxe) || ((val >> fw) == emask);
        unf     = b.flags[3] | (tiny & inexact);
        sbit    = b.mode ? {b.sign, 31'b0} : {16'b0, b.sign, 15'b0};
        inf_w   = b.mode ? 32'h7F80_0000 : 32'h0000_7C00;
        f       = {2'b00, b.flags[2:1], 1'b0};
        if (b.special[1]) begin
            r = b.mode ? 32'h7FC0_0000 : 32'h0000_7E00;
        end else if (b.special[0]) begin
            r = sbit | inf_w;
        end else if (b.mant == '0) begin
            r = sbit;
        end else if (ovf) begin
            r = sbit | inf_w;
            f = {1'b1, unf, b.flags[2:1], 1'b1};
        end
`ifdef FP_ROUND_FTZ_EN
        else if (tiny) begin
            r = sbit;
            f = {1'b0, 1'b1, b.flags[2:1], 1'b1};
        end
`endif
        else begin
            r = sbit | val[31:0];
            f = {1'b0, unf, b.flags[2:1], inexact | b.flags[0]};
        end
        return {r, f};
    endfunction

    function automatic beat_t mk(input logic mode, input logic sign, input logic [1:0] sp,
                                 input logic [48:0] mant, input logic [8:0] exp,
                                 input logic [4:0] fl);
        beat_t b;
        b.mode = mode; b.sign = sign; b.special = sp;
        b.mant = mant; b.exp = exp; b.flags = fl;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t       b;
        logic [63:0] m;
        int          k;
        b.mode  = ($urandom_range(0, 1) == 1);
        b.sign  = ($urandom_range(0, 1) == 1);
        b.flags = 5'($urandom_range(0, 31));
        k = int'($urandom_range(0, 15));
        b.special = (k == 0) ? 2'b01 : (k == 1) ? 2'b10 : (k == 2) ? 2'b11 : 2'b00;
        m = {$urandom, $urandom};
        m[47] = 1'b1;
        case ($urandom_range(0, 7))
            0: m = 64'd0;
            1: m[47] = 1'b0;
            2: m[46:23] = '1;
            3: begin
                if (b.mode) begin m[23] = 1'b1; m[22:0] = '0; end
                else begin m[36] = 1'b1; m[35:0] = '0; end
            end
            default: ;
        endcase
        m[48] = 1'b0;
        b.mant = m[48:0];
        case ($urandom_range(0, 7))
            0: b.exp = b.mode ? 9'd254 : 9'd30;
            1: b.exp = b.mode ? 9'($urandom_range(255, 511)) : 9'($urandom_range(31, 511));
            2: b.exp = 9'd1;
            default: b.exp = b.mode ? 9'($urandom_range(1, 254)) : 9'($urandom_range(1, 30));
        endcase
        return b;
    endfunction

    task automatic drive_beat(input beat_t b);
        MODE_FP = b.mode; SIGN = b.sign; SPECIAL = b.special;
        MANT = b.mant; EXP = b.exp; FLAGS = b.flags;
    endtask

    // Sends one beat with OUT_READY high; returns the first result and how
    // many cycles after the accepting edge OUT_VALID appeared.
    task automatic run_single(input beat_t b, output logic [31:0] res,
                              output logic [4:0] fl, output int lat);
        int guard;
        drive_beat(b);
        IN_VALID = 1'b1;
        #1;
        guard = 0;
        while (!IN_READY && guard < 20) begin
            @(posedge CLK); #2; guard++;
        end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        lat = 1;
        while (!OUT_VALID && lat < 10) begin
            @(posedge CLK); #1; lat++;
        end
        res = RESULT;
        fl  = FLAGS_OUT;
    endtask

    task automatic test_reset();
        RST = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        drive_beat(mk(1'b0, 1'b0, 2'b00, '0, '0, '0));
        #2 RST = 1'b1;
        #1;
        n_vec++;
        if (OUT_VALID !== 1'b0 || RESULT !== 32'h0 || FLAGS_OUT !== 5'h0) begin
            n_bad++;
            $display("FAIL reset_state: valid=%b result=%h flags=%b want 0/00000000/00000",
                     OUT_VALID, RESULT, FLAGS_OUT);
        end
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        n_vec++;
        if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", IN_READY, OUT_VALID);
        end
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
    endtask

    task automatic test_directed();
        beat_t       dv[11];
        logic [31:0] dres[11];
        logic [4:0]  dfl[11];
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
        dv[0]  = mk(1, 0, 2'b00, 49'h0_8000_0000_0000, 9'd127, 5'd0);  dres[0]  = 32'h3F80_0000; dfl[0]  = 5'b00000;
        dv[1]  = mk(1, 0, 2'b00, 49'h0_8000_0080_0000, 9'd127, 5'd0);  dres[1]  = 32'h3F80_0000; dfl[1]  = 5'b00001;
        dv[2]  = mk(1, 0, 2'b00, 49'h0_8000_0180_0000, 9'd127, 5'd0);  dres[2]  = 32'h3F80_0002; dfl[2]  = 5'b00001;
        dv[3]  = mk(1, 0, 2'b00, 49'h0_FFFF_FF80_0000, 9'd127, 5'd0);  dres[3]  = 32'h4000_0000; dfl[3]  = 5'b00001;
        dv[4]  = mk(1, 0, 2'b00, 49'h0_FFFF_FF80_0000, 9'd254, 5'd0);  dres[4]  = 32'h7F80_0000; dfl[4]  = 5'b10001;
        dv[5]  = mk(0, 0, 2'b00, 49'h0_8000_0000_0000, 9'd15,  5'd0);  dres[5]  = 32'h0000_3C00; dfl[5]  = 5'b00000;
        dv[6]  = mk(0, 0, 2'b10, 49'h0_8000_0000_0000, 9'd15,  5'd0);  dres[6]  = 32'h0000_7E00; dfl[6]  = 5'b00000;
`ifdef FP_ROUND_FTZ_EN
        dv[7]  = mk(1, 0, 2'b00, 49'h0_4000_0040_0000, 9'd1,   5'd0);  dres[7]  = 32'h0000_0000; dfl[7]  = 5'b01001;
`else
        dv[7]  = mk(1, 0, 2'b00, 49'h0_4000_0040_0000, 9'd1,   5'd0);  dres[7]  = 32'h0040_0000; dfl[7]  = 5'b01001;
`endif
        dv[8]  = mk(1, 1, 2'b01, 49'h0_8000_0000_0000, 9'd127, 5'h1F); dres[8]  = 32'hFF80_0000; dfl[8]  = 5'b00110;
        dv[9]  = mk(1, 1, 2'b00, 49'h0,                9'd0,   5'h1F); dres[9]  = 32'h8000_0000; dfl[9]  = 5'b00110;
        dv[10] = mk(0, 0, 2'b00, 49'h0_FFF0_0000_0000, 9'd30,  5'd0);  dres[10] = 32'h0000_7C00; dfl[10] = 5'b10001;
        for (int i = 0; i < 11; i++) begin
            run_single(dv[i], r, f, lat);
            n_vec++;
            if (lat !== 2) begin
                n_bad++;
                $display("FAIL latency[%0d]: got %0d cycles want 2", i, lat);
            end
            n_vec++;
            if (r !== dres[i]) begin
                n_bad++;
                $display("FAIL result[%0d]: got %h want %h", i, r, dres[i]);
            end
            n_vec++;
            if (f !== dfl[i]) begin
                n_bad++;
                $display("FAIL flags[%0d]: got %b want %b", i, f, dfl[i]);
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_backpressure();
        beat_t       bp[3];
        logic [36:0] e[3];
        logic [31:0] r0;
        logic [4:0]  f0;
        logic        acc;
        int          sent, got, guard;
        bp[0] = mk(1, 0, 2'b00, 49'h0_8000_0000_0000, 9'd127, 5'd0);
        bp[1] = mk(1, 1, 2'b00, 49'h0_8000_0180_0000, 9'd100, 5'd2);
        bp[2] = mk(0, 0, 2'b00, 49'h0_8000_0000_0000, 9'd15,  5'd0);
        for (int i = 0; i < 3; i++) e[i] = ref_model(bp[i]);
        OUT_READY = 1'b0;
        sent = 0;
        for (int c = 0; c < 3; c++) begin
            drive_beat(bp[sent]);
            IN_VALID = 1'b1;
            #1;
            acc = IN_READY;
            @(posedge CLK); #1;
            if (acc) sent++;
        end
        drive_beat(bp[sent > 2 ? 2 : sent]);
        #1;
        n_vec++;
        if (sent !== 2) begin
            n_bad++;
            $display("FAIL bp_accepted: got %0d beats want 2", sent);
        end
        n_vec++;
        if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_full: in_ready=%b out_valid=%b want 0/1", IN_READY, OUT_VALID);
        end
        r0 = RESULT;
        f0 = FLAGS_OUT;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #2;
            n_vec++;
            if (RESULT !== r0 || FLAGS_OUT !== f0 || OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_stall_hold: result=%h flags=%b valid=%b ready=%b want %h/%b/1/0",
                         RESULT, FLAGS_OUT, OUT_VALID, IN_READY, r0, f0);
            end
        end
        OUT_READY = 1'b1;
        #1;
        got = 0;
        guard = 0;
        while (got < 3 && guard < 20) begin
            acc = IN_VALID & IN_READY;
            if (OUT_VALID && OUT_READY) begin
                n_vec++;
                if ({RESULT, FLAGS_OUT} !== e[got]) begin
                    n_bad++;
                    $display("FAIL bp_order[%0d]: got %h/%b want %h/%b", got, RESULT, FLAGS_OUT,
                             e[got][36:5], e[got][4:0]);
                end
                got++;
            end
            @(posedge CLK); #1;
            if (acc) sent++;
            if (sent < 3) begin
                drive_beat(bp[sent]);
                IN_VALID = 1'b1;
            end else begin
                IN_VALID = 1'b0;
            end
            #1;
            guard++;
        end
        n_vec++;
        if (got !== 3) begin
            n_bad++;
            $display("FAIL bp_drain: got %0d results want 3", got);
        end
        IN_VALID = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_random(input int ncycles);
        beat_t       b;
        logic [36:0] exp_q[$];
        logic [36:0] e;
        logic [31:0] hold_res;
        logic [4:0]  hold_fl;
        logic        stall, holding;
        stall = 1'b0;
        holding = 1'b0;
        hold_res = '0;
        hold_fl = '0;
        b = rand_beat();
        for (int c = 0; c < ncycles; c++) begin
            if (!holding) begin
                b = rand_beat();
                IN_VALID = ($urandom_range(0, 3) != 0);
            end
            drive_beat(b);
            OUT_READY = ($urandom_range(0, 4) > 1);
            #1;
            if (stall) begin
                n_vec++;
                if (OUT_VALID !== 1'b1 || RESULT !== hold_res || FLAGS_OUT !== hold_fl) begin
                    n_bad++;
                    $display("FAIL rand_stall_hold: valid=%b result=%h flags=%b want 1/%h/%b",
                             OUT_VALID, RESULT, FLAGS_OUT, hold_res, hold_fl);
                end
            end
            if (OUT_VALID && OUT_READY) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand_spurious: result %h emitted with no beat outstanding", RESULT);
                end else begin
                    e = exp_q.pop_front();
                    if ({RESULT, FLAGS_OUT} !== e) begin
                        n_bad++;
                        $display("FAIL rand_result: got %h/%b want %h/%b",
                                 RESULT, FLAGS_OUT, e[36:5], e[4:0]);
                    end
                end
            end
            stall    = OUT_VALID && !OUT_READY;
            hold_res = RESULT;
            hold_fl  = FLAGS_OUT;
            holding  = IN_VALID && !IN_READY;
            if (IN_VALID && IN_READY) exp_q.push_back(ref_model(b));
            @(posedge CLK); #1;
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (OUT_VALID) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand_drain_spurious: result %h", RESULT);
                end else begin
                    e = exp_q.pop_front();
                    if ({RESULT, FLAGS_OUT} !== e) begin
                        n_bad++;
                        $display("FAIL rand_drain_result: got %h/%b want %h/%b",
                                 RESULT, FLAGS_OUT, e[36:5], e[4:0]);
                    end
                end
            end
            @(posedge CLK); #1;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rand_lost: %0d results never emerged want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic [36:0] e0;
        beat_t       b0, b1;
        b0 = mk(1, 0, 2'b00, 49'h0_8000_0080_0000, 9'd127, 5'd0);
        b1 = mk(1, 1, 2'b00, 49'h0_FFFF_FF80_0000, 9'd127, 5'd0);
        e0 = ref_model(b0);
        OUT_READY = 1'b0;
        drive_beat(b0);
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        drive_beat(b1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        #1;
        n_vec++;
        if (OUT_VALID !== 1'b1 || {RESULT, FLAGS_OUT} !== e0) begin
            n_bad++;
            $display("FAIL rst_pre: valid=%b result=%h/%b want 1/%h/%b",
                     OUT_VALID, RESULT, FLAGS_OUT, e0[36:5], e0[4:0]);
        end
        RST = 1'b1;
        #1;
        n_vec++;
        if (OUT_VALID !== 1'b0 || RESULT !== 32'h0 || FLAGS_OUT !== 5'h0) begin
            n_bad++;
            $display("FAIL rst_mid: valid=%b result=%h flags=%b want 0/00000000/00000",
                     OUT_VALID, RESULT, FLAGS_OUT);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        n_vec++;
        if (IN_READY !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_in_ready: got %b want 1", IN_READY);
        end
        OUT_READY = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK); #1;
            n_vec++;
            if (OUT_VALID !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_discard[%0d]: out_valid=%b want 0", c, OUT_VALID);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random(800);
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
